// File: rtl/sh7034_int_seq_if.sv
// Interrupt-controller handshake and memory bus between the interrupt
// exception sequencer (master) and the controller / bus fabric (slave).
interface sh7034_int_seq_if;
    logic        INT_REQ;
    logic [3:0]  INT_LVL;
    logic [7:0]  INT_VEC;
    logic [3:0]  INT_MASK;
    logic        INT_ACK;
    logic        INT_ACP;
    logic        VECT_REQ;
    logic        VECT_WAIT;
    logic [31:0] BUS_A;
    logic [31:0] BUS_DO;
    logic [31:0] BUS_DI;
    logic        BUS_WE;
    logic        BUS_REQ;
    logic        BUS_BUSY;

    modport master (
        input  INT_REQ, INT_LVL, INT_VEC, VECT_WAIT, BUS_DI, BUS_BUSY,
        output INT_MASK, INT_ACK, INT_ACP, VECT_REQ, BUS_A, BUS_DO, BUS_WE, BUS_REQ
    );

    modport slave (
        output INT_REQ, INT_LVL, INT_VEC, VECT_WAIT, BUS_DI, BUS_BUSY,
        input  INT_MASK, INT_ACK, INT_ACP, VECT_REQ, BUS_A, BUS_DO, BUS_WE, BUS_REQ
    );
endinterface

// File: rtl/sh7034_int_seq.sv
// SH7034 CPU-side interrupt exception sequencer: accepts a pending interrupt
// at an instruction boundary, handshakes the vector, pushes SR and PC on the
// R15 stack, fetches the handler address and hands PC/SR/R15 to the core.
// Every bus access spends one CE_R with BUS_REQ low before requesting, so
// consecutive accesses are always separated by an idle slot.
module sh7034_int_seq (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    CE_R,
    input  logic                    CE_F,
    sh7034_int_seq_if.master        bus,
    input  logic                    BOUNDARY,
    input  logic [31:0]             SR_IN,
    input  logic [31:0]             PC_IN,
    input  logic [31:0]             R15_IN,
    input  logic [31:0]             VBR_IN,
    output logic                    SEQ_BUSY,
    output logic                    LOAD,
    output logic [31:0]             NEW_PC,
    output logic [31:0]             NEW_SR,
    output logic [31:0]             NEW_R15
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_VEC,
        S_PUSH_SR,
        S_PUSH_PC,
        S_FETCH,
        S_DONE
    } state_t;

    state_t      state, state_next;
    logic        phase, phase_next;
    logic [1:0]  vcnt, vcnt_next;

    logic [3:0]  lvl;
    logic [7:0]  vec;
    logic [31:0] sr;
    logic [31:0] pc;
    logic [31:0] sp;
    logic [31:0] new_pc;

    logic        accept;
    logic        bus_done;
    logic        int_ack;
    logic        int_acp;
    logic        vect_req;
    logic        bus_we;
    logic        bus_req;
    logic [31:0] bus_a;
    logic [31:0] bus_do;

    // CE_F is carried only for symmetry with the other CPU blocks
    logic        ce_f_unused;
    assign ce_f_unused = CE_F;

    // Level F (NMI/UBC) bypasses the SR mask
    assign accept = bus.INT_REQ && BOUNDARY &&
                    ((bus.INT_LVL > SR_IN[7:4]) || (bus.INT_LVL == 4'hF));

    // State register; async reset aborts any sequence in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
            phase <= 1'b0;
            vcnt  <= 2'd0;
        end else if (CE_R) begin
            state <= state_next;
            phase <= phase_next;
            vcnt  <= vcnt_next;
        end
    end

    // Next-state and output decode; phase selects request/wait sub-steps
    always_comb begin
        state_next = state;
        phase_next = phase;
        vcnt_next  = vcnt;
        int_ack    = 1'b0;
        int_acp    = (state != S_IDLE);
        vect_req   = 1'b0;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_a      = 32'd0;
        bus_do     = 32'd0;
        bus_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_ACK;
                    phase_next = 1'b0;
                    vcnt_next  = 2'd0;
                end
            end
            S_ACK: begin
                int_ack    = 1'b1;
                vect_req   = 1'b1;
                state_next = S_VEC;
                phase_next = 1'b0;
                vcnt_next  = 2'd0;
            end
            S_VEC: begin
                if (!phase) begin
                    vect_req = 1'b1;
                    if (bus.VECT_WAIT) begin
                        phase_next = 1'b1;
                    end else if (vcnt == 2'd3) begin
                        state_next = S_PUSH_SR;
                        phase_next = 1'b0;
                    end else begin
                        vcnt_next = vcnt + 2'd1;
                    end
                end else if (!bus.VECT_WAIT) begin
                    state_next = S_PUSH_SR;
                    phase_next = 1'b0;
                end
            end
            S_PUSH_SR: begin
                bus_a   = sp - 32'd4;
                bus_do  = sr;
                bus_we  = 1'b1;
                bus_req = phase;
                if (!phase) begin
                    phase_next = 1'b1;
                end else if (!bus.BUS_BUSY) begin
                    bus_done   = 1'b1;
                    state_next = S_PUSH_PC;
                    phase_next = 1'b0;
                end
            end
            S_PUSH_PC: begin
                bus_a   = sp - 32'd4;
                bus_do  = pc;
                bus_we  = 1'b1;
                bus_req = phase;
                if (!phase) begin
                    phase_next = 1'b1;
                end else if (!bus.BUS_BUSY) begin
                    bus_done   = 1'b1;
                    state_next = S_FETCH;
                    phase_next = 1'b0;
                end
            end
            S_FETCH: begin
                bus_a   = VBR_IN + {22'b0, vec, 2'b00};
                bus_req = phase;
                if (!phase) begin
                    phase_next = 1'b1;
                end else if (!bus.BUS_BUSY) begin
                    bus_done   = 1'b1;
                    state_next = S_DONE;
                    phase_next = 1'b0;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                phase_next = 1'b0;
            end
        endcase
    end

    // Latch the interrupt context on acceptance, walk SP down, capture handler
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lvl    <= 4'd0;
            vec    <= 8'd0;
            sr     <= 32'd0;
            pc     <= 32'd0;
            sp     <= 32'd0;
            new_pc <= 32'd0;
        end else if (CE_R) begin
            if ((state == S_IDLE) && accept) begin
                lvl <= bus.INT_LVL;
                vec <= bus.INT_VEC;
                sr  <= SR_IN;
                pc  <= PC_IN;
                sp  <= R15_IN;
            end
            if (bus_done && (state != S_FETCH)) begin
                sp <= sp - 32'd4;
            end
            if (bus_done && (state == S_FETCH)) begin
                new_pc <= bus.BUS_DI;
            end
        end
    end

    assign bus.INT_MASK = SR_IN[7:4];
    assign bus.INT_ACK  = int_ack;
    assign bus.INT_ACP  = int_acp;
    assign bus.VECT_REQ = vect_req;
    assign bus.BUS_A    = bus_a;
    assign bus.BUS_DO   = bus_do;
    assign bus.BUS_WE   = bus_we;
    assign bus.BUS_REQ  = bus_req;

    assign SEQ_BUSY = int_acp;
    assign LOAD     = (state == S_DONE);
    assign NEW_PC   = new_pc;
    assign NEW_SR   = {sr[31:8], lvl, sr[3:0]};
    assign NEW_R15  = sp;

endmodule

// File: tb/tb_sh7034_int_seq.sv
// Testbench for sh7034_int_seq: directed interrupt sequences with a
// scoreboard of expected bus accesses and LOAD results, a small interrupt
// controller / bus slave model, and CE_R running at half the clock rate.
module tb_sh7034_int_seq;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
    } bus_exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] sr;
        logic [31:0] r15;
        int          lat;
    } load_exp_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CE_R;
    logic        CE_F;
    logic        BOUNDARY;
    logic [31:0] SR_IN;
    logic [31:0] PC_IN;
    logic [31:0] R15_IN;
    logic [31:0] VBR_IN;
    logic        SEQ_BUSY;
    logic        LOAD;
    logic [31:0] NEW_PC;
    logic [31:0] NEW_SR;
    logic [31:0] NEW_R15;

    sh7034_int_seq_if bus_if ();

    sh7034_int_seq dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CE_R     (CE_R),
        .CE_F     (CE_F),
        .bus      (bus_if),
        .BOUNDARY (BOUNDARY),
        .SR_IN    (SR_IN),
        .PC_IN    (PC_IN),
        .R15_IN   (R15_IN),
        .VBR_IN   (VBR_IN),
        .SEQ_BUSY (SEQ_BUSY),
        .LOAD     (LOAD),
        .NEW_PC   (NEW_PC),
        .NEW_SR   (NEW_SR),
        .NEW_R15  (NEW_R15)
    );

    bus_exp_t  exp_bus[$];
    load_exp_t exp_load[$];
    int        errors = 0;
    int        checks = 0;
    int        ce_cnt = 0;
    int        load_seen = 0;
    int        bus_wait_cfg = 0;
    int        vw_cfg = 1;

    // 10 ns system clock
    initial forever #5 CLK = ~CLK;

    // CE_R active on every second rising edge
    initial begin
        CE_R = 1'b0;
        CE_F = 1'b1;
        forever begin
            @(negedge CLK);
            CE_R = ~CE_R;
            CE_F = ~CE_R;
        end
    end

    task automatic ce_edge;
        do @(posedge CLK); while (!CE_R);
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got event expected none", name);
    endtask

    // Environment: scoreboard monitor, vector-handshake model and bus slave
    initial begin : env
        logic        in_acc, pend_valid, pend_we, prev_acp, prev_vreq;
        logic [31:0] pend_a, pend_do, snap_a, snap_do;
        logic        snap_we;
        int          left, vw_left, acc_ce, ack_cnt;
        bus_exp_t    be;
        load_exp_t   le;
        in_acc = 0; pend_valid = 0; pend_we = 0; prev_acp = 0; prev_vreq = 0;
        pend_a = 0; pend_do = 0; snap_a = 0; snap_do = 0; snap_we = 0;
        left = 0; vw_left = 0; acc_ce = 0; ack_cnt = 0;
        bus_if.BUS_BUSY  = 1'b0;
        bus_if.BUS_DI    = 32'hDEAD_BEEF;
        bus_if.VECT_WAIT = 1'b0;
        forever begin
            ce_edge();
            ce_cnt++;
            #1;
            if (!RST_N) begin
                in_acc = 0; pend_valid = 0; prev_acp = 0; prev_vreq = 0;
                left = 0; vw_left = 0; ack_cnt = 0;
                bus_if.BUS_BUSY  = 1'b0;
                bus_if.VECT_WAIT = 1'b0;
                continue;
            end
            if (pend_valid) begin
                check_output("bus_gap", 32'(bus_if.BUS_REQ), 32'd0);
                if (exp_bus.size() == 0) begin
                    report_fail("unexpected_bus");
                end else begin
                    be = exp_bus.pop_front();
                    check_output("bus_we", 32'(pend_we), 32'(be.we));
                    check_output("bus_addr", pend_a, be.a);
                    if (be.we) check_output("bus_data", pend_do, be.d);
                end
            end
            if (bus_if.INT_ACP && !prev_acp) begin
                acc_ce  = ce_cnt;
                ack_cnt = 0;
                if (exp_load.size() == 0) report_fail("unexpected_accept");
            end
            prev_acp = bus_if.INT_ACP;
            if (bus_if.INT_ACK) ack_cnt++;
            if (LOAD) begin
                load_seen++;
                if (exp_load.size() == 0) begin
                    report_fail("unexpected_load");
                end else begin
                    le = exp_load.pop_front();
                    check_output("new_pc", NEW_PC, le.pc);
                    check_output("new_sr", NEW_SR, le.sr);
                    check_output("new_r15", NEW_R15, le.r15);
                    // CE_R periods from the ACK state up to and including LOAD
                    check_output("latency", 32'(ce_cnt - acc_ce + 1), 32'(le.lat));
                    check_output("int_ack_pulses", 32'(ack_cnt), 32'd1);
                end
            end
            if (bus_if.VECT_WAIT) begin
                if (vw_left > 1) vw_left--;
                else begin
                    vw_left = 0;
                    bus_if.VECT_WAIT = 1'b0;
                end
            end else if (prev_vreq && vw_cfg > 0) begin
                bus_if.VECT_WAIT = 1'b1;
                vw_left = vw_cfg;
            end
            prev_vreq = bus_if.VECT_REQ;
            if (bus_if.BUS_REQ) begin
                if (!in_acc) begin
                    in_acc  = 1;
                    left    = bus_wait_cfg;
                    snap_a  = bus_if.BUS_A;
                    snap_do = bus_if.BUS_DO;
                    snap_we = bus_if.BUS_WE;
                end else begin
                    check_output("hold_addr", bus_if.BUS_A, snap_a);
                    check_output("hold_data", bus_if.BUS_DO, snap_do);
                    check_output("hold_we", 32'(bus_if.BUS_WE), 32'(snap_we));
                    if (left > 0) left--;
                end
            end else begin
                in_acc = 0;
            end
            bus_if.BUS_BUSY = in_acc && (left > 0);
            bus_if.BUS_DI = (bus_if.BUS_REQ && !bus_if.BUS_WE && !bus_if.BUS_BUSY) ?
                            (32'h8000_0000 | bus_if.BUS_A) : 32'hDEAD_BEEF;
            pend_valid = bus_if.BUS_REQ && !bus_if.BUS_BUSY;
            pend_we    = bus_if.BUS_WE;
            pend_a     = bus_if.BUS_A;
            pend_do    = bus_if.BUS_DO;
        end
    end

    task automatic push_expect(input logic [31:0] sr, input logic [31:0] pc,
                               input logic [31:0] a_sr, input logic [31:0] a_pc,
                               input logic [31:0] a_fetch, input logic [31:0] e_pc,
                               input logic [31:0] e_sr, input logic [31:0] e_r15, input int e_lat);
        bus_exp_t  b;
        load_exp_t l;
        b.we = 1'b1; b.a = a_sr;    b.d = sr;    exp_bus.push_back(b);
        b.we = 1'b1; b.a = a_pc;    b.d = pc;    exp_bus.push_back(b);
        b.we = 1'b0; b.a = a_fetch; b.d = 32'd0; exp_bus.push_back(b);
        l.pc = e_pc; l.sr = e_sr; l.r15 = e_r15; l.lat = e_lat;
        exp_load.push_back(l);
    endtask

    task automatic check_no_accept(input logic [31:0] sr, input logic [3:0] lvl, input logic bnd);
        ce_edge(); #2;
        SR_IN = sr;
        bus_if.INT_LVL = lvl;
        bus_if.INT_VEC = 8'd64;
        BOUNDARY = bnd;
        bus_if.INT_REQ = 1'b1;
        repeat (4) ce_edge();
        #2;
        check_output("no_accept", 32'(SEQ_BUSY), 32'd0);
        check_output("int_mask", 32'(bus_if.INT_MASK), 32'(sr[7:4]));
        bus_if.INT_REQ = 1'b0;
        BOUNDARY = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [31:0] sr, input logic [31:0] pc,
                                  input logic [31:0] r15, input logic [31:0] vbr,
                                  input logic [3:0] lvl, input logic [7:0] vec,
                                  input int bwait, input int vw,
                                  input logic [31:0] a_sr, input logic [31:0] a_pc,
                                  input logic [31:0] a_fetch, input logic [31:0] e_pc,
                                  input logic [31:0] e_sr, input logic [31:0] e_r15, input int e_lat);
        bit got;
        int n;
        ce_edge(); #2;
        bus_wait_cfg = bwait;
        vw_cfg = vw;
        SR_IN = sr; PC_IN = pc; R15_IN = r15; VBR_IN = vbr;
        bus_if.INT_LVL = lvl;
        bus_if.INT_VEC = vec;
        push_expect(sr, pc, a_sr, a_pc, a_fetch, e_pc, e_sr, e_r15, e_lat);
        bus_if.INT_REQ = 1'b1;
        BOUNDARY = 1'b1;
        got = 0;
        for (int i = 0; i < 12; i++) begin
            ce_edge(); #2;
            if (SEQ_BUSY) begin got = 1; break; end
        end
        if (!got) begin
            report_fail("accept_timeout");
            exp_bus.delete(); exp_load.delete();
            bus_if.INT_REQ = 1'b0;
            return;
        end
        // Live inputs change after acceptance; the latched context must be used
        bus_if.INT_LVL = 4'hF;
        bus_if.INT_VEC = 8'hEE;
        SR_IN  = 32'hFFFF_FFFF;
        PC_IN  = 32'hBAD0_BAD0;
        R15_IN = 32'h5555_5555;
        n = load_seen;
        got = 0;
        for (int i = 0; i < 60; i++) begin
            ce_edge(); #2;
            if (load_seen != n) begin got = 1; break; end
        end
        bus_if.INT_REQ = 1'b0;
        BOUNDARY = 1'b0;
        if (!got) begin
            report_fail("load_timeout");
            exp_bus.delete(); exp_load.delete();
        end
        ce_edge(); #2;
        check_output("seq_busy_drop", 32'(SEQ_BUSY), 32'd0);
        check_output("int_acp_drop", 32'(bus_if.INT_ACP), 32'd0);
    endtask

    task automatic apply_reset_mid;
        bit got;
        int n;
        ce_edge(); #2;
        bus_wait_cfg = 3;
        vw_cfg = 1;
        SR_IN = 32'd0; PC_IN = 32'h0000_4444; R15_IN = 32'h0000_2000; VBR_IN = 32'd0;
        bus_if.INT_LVL = 4'd3;
        bus_if.INT_VEC = 8'd5;
        push_expect(32'd0, 32'h0000_4444, 32'h0000_1FFC, 32'h0000_1FF8, 32'h0000_0014,
                    32'h8000_0014, 32'h0000_0030, 32'h0000_1FF8, 25);
        bus_if.INT_REQ = 1'b1;
        BOUNDARY = 1'b1;
        got = 0;
        for (int i = 0; i < 60; i++) begin
            ce_edge(); #2;
            if (SEQ_BUSY) bus_if.INT_REQ = 1'b0;
            if (bus_if.BUS_REQ && bus_if.BUS_WE && bus_if.BUS_A == 32'h0000_1FF8 && bus_if.BUS_BUSY) begin
                got = 1;
                break;
            end
        end
        if (!got) report_fail("push_pc_wait_timeout");
        bus_if.INT_REQ = 1'b0;
        BOUNDARY = 1'b0;
        #1;
        RST_N = 1'b0;
        #1;
        check_output("rst_bus_req", 32'(bus_if.BUS_REQ), 32'd0);
        check_output("rst_seq_busy", 32'(SEQ_BUSY), 32'd0);
        check_output("rst_int_acp", 32'(bus_if.INT_ACP), 32'd0);
        check_output("rst_load", 32'(LOAD), 32'd0);
        exp_bus.delete();
        exp_load.delete();
        n = load_seen;
        repeat (2) ce_edge();
        #2;
        RST_N = 1'b1;
        repeat (15) ce_edge();
        #2;
        check_output("no_load_after_reset", 32'(load_seen), 32'(n));
    endtask

    // Directed stimulus sequence
    initial begin
        RST_N = 1'b0;
        BOUNDARY = 1'b0;
        SR_IN = 32'h0000_00A0; PC_IN = 32'd0; R15_IN = 32'd0; VBR_IN = 32'd0;
        bus_if.INT_REQ = 1'b0;
        bus_if.INT_LVL = 4'd0;
        bus_if.INT_VEC = 8'd0;
        repeat (3) ce_edge();
        #2;
        check_output("reset_seq_busy", 32'(SEQ_BUSY), 32'd0);
        check_output("reset_int_acp", 32'(bus_if.INT_ACP), 32'd0);
        check_output("reset_int_ack", 32'(bus_if.INT_ACK), 32'd0);
        check_output("reset_vect_req", 32'(bus_if.VECT_REQ), 32'd0);
        check_output("reset_bus_req", 32'(bus_if.BUS_REQ), 32'd0);
        check_output("reset_bus_a", bus_if.BUS_A, 32'd0);
        check_output("reset_load", 32'(LOAD), 32'd0);
        check_output("reset_new_pc", NEW_PC, 32'd0);
        check_output("reset_new_sr", NEW_SR, 32'd0);
        check_output("reset_new_r15", NEW_R15, 32'd0);
        check_output("reset_int_mask", 32'(bus_if.INT_MASK), 32'h0000_000A);
        RST_N = 1'b1;

        check_no_accept(32'h0000_00F0, 4'd5, 1'b1);
        check_no_accept(32'h0000_0050, 4'd5, 1'b1);
        check_no_accept(32'h0000_0030, 4'd5, 1'b0);

        // Basic IRQ: level 5 over mask 3, vector 64
        apply_stimulus(32'h0000_0030, 32'h0000_2468, 32'h0F00_0100, 32'h0000_1000, 4'd5, 8'd64, 0, 1,
                       32'h0F00_00FC, 32'h0F00_00F8, 32'h0000_1100,
                       32'h8000_1100, 32'h0000_0050, 32'h0F00_00F8, 10);
        // NMI: level F taken under mask F, vector 11
        apply_stimulus(32'h3000_00F1, 32'h0000_3000, 32'h0F00_0100, 32'h0000_1000, 4'hF, 8'd11, 0, 1,
                       32'h0F00_00FC, 32'h0F00_00F8, 32'h0000_102C,
                       32'h8000_102C, 32'h3000_00F1, 32'h0F00_00F8, 10);
        // Three busy cycles on every bus access
        apply_stimulus(32'h0000_0021, 32'h0000_ABCE, 32'h0080_0000, 32'h0000_2000, 4'd9, 8'd80, 3, 1,
                       32'h007F_FFFC, 32'h007F_FFF8, 32'h0000_2140,
                       32'h8000_2140, 32'h0000_0091, 32'h007F_FFF8, 19);
        // VECT_WAIT held for five CE_R
        apply_stimulus(32'h0000_0000, 32'h0000_0600, 32'h0000_1000, 32'h0000_0400, 4'd1, 8'd32, 0, 5,
                       32'h0000_0FFC, 32'h0000_0FF8, 32'h0000_0480,
                       32'h8000_0480, 32'h0000_0010, 32'h0000_0FF8, 14);
        // Stack and vector-table address wrap-around
        apply_stimulus(32'h0000_0040, 32'h1234_5678, 32'h0000_0004, 32'hFFFF_FF00, 4'd7, 8'd72, 0, 1,
                       32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0020,
                       32'h8000_0020, 32'h0000_0070, 32'hFFFF_FFFC, 10);

        apply_reset_mid();

        // Fresh request after reset, controller never raises VECT_WAIT
        apply_stimulus(32'h0000_0010, 32'h0000_0800, 32'h0000_3000, 32'h0000_0100, 4'd2, 8'd1, 0, 0,
                       32'h0000_2FFC, 32'h0000_2FF8, 32'h0000_0104,
                       32'h8000_0104, 32'h0000_0020, 32'h0000_2FF8, 12);

        check_output("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
        check_output("load_queue_empty", 32'(exp_load.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
